// File: rtl/driver_pwm_pkg.sv
// Shared codes for the PWM motor driver: direction commands, channel states
// and a small duty helper.
package driver_pwm_pkg;

    localparam int unsigned DUTY_W = 12;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_COAST = 2'b00;
    localparam dir_t DIR_FWD   = 2'b01;
    localparam dir_t DIR_REV   = 2'b10;
    localparam dir_t DIR_BRAKE = 2'b11;

    localparam logic [1:0] ST_COAST = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DEAD  = 2'd2;
    localparam logic [1:0] ST_BRAKE = 2'd3;

    function automatic logic [DUTY_W-1:0] min_duty(input logic [DUTY_W-1:0] a,
                                                   input logic [DUTY_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/canal_pwm.sv
// One H-bridge channel: direction FSM, soft-start ramp, reversal dead time and
// registered PWM compare. All decisions are taken at PWM period boundaries.
module canal_pwm
    import driver_pwm_pkg::*;
#(
    parameter int unsigned PERIOADA  = 1000,
    parameter int unsigned RAMPA_PAS = 50,
    parameter int unsigned DEAD_PER  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boundary,
    input  logic [DUTY_W-1:0] cnt_next,
    input  logic [1:0]        dir,
    input  logic [DUTY_W-1:0] factor_dc,
    output logic              in1,
    output logic              in2,
    output logic              pwm
);

    localparam int unsigned       DW        = 8;
    localparam logic [DUTY_W-1:0] PER_MAX   = DUTY_W'(PERIOADA);
    localparam logic [DUTY_W-1:0] RAMP_MAX  = DUTY_W'(RAMPA_PAS);
    localparam logic [DW-1:0]     DEAD_INIT = DW'(DEAD_PER - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        dir_q, dir_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DW-1:0]     dead_q, dead_d;
    logic [DUTY_W-1:0] tgt, start_duty;
    logic              eval_coast;
    logic              in1_d, in2_d, pwm_d;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        duty_d     = duty_q;
        dead_d     = dead_q;
        eval_coast = 1'b0;
        tgt        = min_duty(factor_dc, PER_MAX);
        start_duty = min_duty(tgt, RAMP_MAX);

        if (boundary) begin
            unique case (state_q)
                ST_COAST: eval_coast = 1'b1;
                ST_DEAD: begin
                    if (dead_q == '0) begin
                        eval_coast = 1'b1;
                    end else begin
                        dead_d = dead_q - 1'b1;
                    end
                end
                ST_BRAKE: begin
                    if (dir == DIR_COAST) begin
                        state_d = ST_COAST;
                        duty_d  = '0;
                    end else if (dir == DIR_FWD || dir == DIR_REV) begin
                        state_d = ST_RUN;
                        dir_d   = dir;
                        duty_d  = start_duty;
                    end
                end
                ST_RUN: begin
                    if (dir == dir_q) begin
                        // Increase is rate-limited, decrease takes effect at once.
                        if (tgt > duty_q) begin
                            duty_d = duty_q + min_duty(RAMP_MAX, tgt - duty_q);
                        end else begin
                            duty_d = tgt;
                        end
                    end else if (dir == DIR_COAST) begin
                        state_d = ST_COAST;
                        duty_d  = '0;
                    end else if (dir == DIR_BRAKE) begin
                        state_d = ST_BRAKE;
                        duty_d  = '0;
                    end else begin
                        state_d = ST_DEAD;
                        duty_d  = '0;
                        dead_d  = DEAD_INIT;
                    end
                end
            endcase

            if (eval_coast) begin
                if (dir == DIR_FWD || dir == DIR_REV) begin
                    state_d = ST_RUN;
                    dir_d   = dir;
                    duty_d  = start_duty;
                end else if (dir == DIR_BRAKE) begin
                    state_d = ST_BRAKE;
                    duty_d  = '0;
                end else begin
                    state_d = ST_COAST;
                    duty_d  = '0;
                end
            end
        end

        // Outputs are precomputed against the counter value of the next clk.
        in1_d = ((state_d == ST_RUN) && (dir_d == DIR_FWD)) || (state_d == ST_BRAKE);
        in2_d = ((state_d == ST_RUN) && (dir_d == DIR_REV)) || (state_d == ST_BRAKE);
        pwm_d = ((state_d == ST_RUN) && (cnt_next < duty_d)) || (state_d == ST_BRAKE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COAST;
            dir_q   <= DIR_COAST;
            duty_q  <= '0;
            dead_q  <= '0;
            in1     <= 1'b0;
            in2     <= 1'b0;
            pwm     <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            duty_q  <= duty_d;
            dead_q  <= dead_d;
            in1     <= in1_d;
            in2     <= in2_d;
            pwm     <= pwm_d;
        end
    end

endmodule

// File: rtl/driver_pwm_motor.sv
// Dual-channel H-bridge PWM driver: input registers, shared prescaler and period
// counter, period-start pulse, and two independent channel instances.
module driver_pwm_motor
    import driver_pwm_pkg::*;
#(
    parameter int unsigned PRESCALER = 50,
    parameter int unsigned PERIOADA  = 1000,
    parameter int unsigned RAMPA_PAS = 50,
    parameter int unsigned DEAD_PER  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  directie_driverA,
    input  logic [1:0]  directie_driverB,
    input  logic [11:0] factor_dc_driverA,
    input  logic [11:0] factor_dc_driverB,
    output logic        in1_A,
    output logic        in2_A,
    output logic        in1_B,
    output logic        in2_B,
    output logic        pwm_A,
    output logic        pwm_B,
    output logic        inceput_perioada
);

    localparam int unsigned       PW        = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
    localparam logic [PW-1:0]     PRESC_MAX = PW'(PRESCALER - 1);
    localparam logic [DUTY_W-1:0] CNT_MAX   = DUTY_W'(PERIOADA - 1);

    logic [1:0]        dir_a_q, dir_b_q;
    logic [DUTY_W-1:0] dc_a_q, dc_b_q;
    logic [PW-1:0]     presc_q;
    logic [DUTY_W-1:0] cnt_q, cnt_next;
    logic              inceput_q;
    logic              tick, boundary;

    always_comb begin
        tick     = (presc_q == PRESC_MAX);
        boundary = tick && (cnt_q == CNT_MAX);
        cnt_next = cnt_q;
        if (tick) begin
            cnt_next = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    // Upstream logic is combinational, so commands are sampled once here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_a_q   <= DIR_COAST;
            dir_b_q   <= DIR_COAST;
            dc_a_q    <= '0;
            dc_b_q    <= '0;
            presc_q   <= '0;
            cnt_q     <= '0;
            inceput_q <= 1'b0;
        end else begin
            dir_a_q   <= directie_driverA;
            dir_b_q   <= directie_driverB;
            dc_a_q    <= factor_dc_driverA;
            dc_b_q    <= factor_dc_driverB;
            presc_q   <= tick ? '0 : presc_q + 1'b1;
            cnt_q     <= cnt_next;
            inceput_q <= boundary;
        end
    end

    assign inceput_perioada = inceput_q;

    canal_pwm #(
        .PERIOADA  (PERIOADA),
        .RAMPA_PAS (RAMPA_PAS),
        .DEAD_PER  (DEAD_PER)
    ) u_canal_a (
        .clk       (clk),
        .rst       (rst),
        .boundary  (boundary),
        .cnt_next  (cnt_next),
        .dir       (dir_a_q),
        .factor_dc (dc_a_q),
        .in1       (in1_A),
        .in2       (in2_A),
        .pwm       (pwm_A)
    );

    canal_pwm #(
        .PERIOADA  (PERIOADA),
        .RAMPA_PAS (RAMPA_PAS),
        .DEAD_PER  (DEAD_PER)
    ) u_canal_b (
        .clk       (clk),
        .rst       (rst),
        .boundary  (boundary),
        .cnt_next  (cnt_next),
        .dir       (dir_b_q),
        .factor_dc (dc_b_q),
        .in1       (in1_B),
        .in2       (in2_B),
        .pwm       (pwm_B)
    );

endmodule

// File: tb/tb_driver_pwm_motor.sv
// Bench for driver_pwm_motor: per-period directed table, async reset sequence and
// randomized commands checked every clk against a period-level reference model.
module tb_driver_pwm_motor;

    localparam int PS       = 2;
    localparam int PER      = 10;
    localparam int RAMP     = 3;
    localparam int DEADP    = 2;
    localparam int CLKS_PER = PS * PER;
    localparam int NV       = 18;

    localparam int M_OFF   = 0;
    localparam int M_DRIVE = 1;
    localparam int M_GAP   = 2;
    localparam int M_HOLD  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  dir_a = 2'b00, dir_b = 2'b00;
    logic [11:0] dc_a = 12'd0, dc_b = 12'd0;
    logic        in1_a, in2_a, in1_b, in2_b, pwm_a, pwm_b, ip;

    int checks = 0;
    int errors = 0;

    driver_pwm_motor #(
        .PRESCALER (PS),
        .PERIOADA  (PER),
        .RAMPA_PAS (RAMP),
        .DEAD_PER  (DEADP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .directie_driverA  (dir_a),
        .directie_driverB  (dir_b),
        .factor_dc_driverA (dc_a),
        .factor_dc_driverB (dc_b),
        .in1_A             (in1_a),
        .in2_A             (in2_a),
        .in1_B             (in1_b),
        .in2_B             (in2_b),
        .pwm_A             (pwm_a),
        .pwm_B             (pwm_b),
        .inceput_perioada  (ip)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (one decision per PWM period) ----------------
    int   m_n = 0;
    int   m_mode[2] = '{M_OFF, M_OFF};
    int   m_sense[2] = '{0, 0};
    int   m_duty[2] = '{0, 0};
    int   m_gap[2] = '{0, 0};
    int   m_cmd_dir[2] = '{0, 0};
    int   m_cmd_dc[2] = '{0, 0};
    logic e_in1[2] = '{1'b0, 1'b0};
    logic e_in2[2] = '{1'b0, 1'b0};
    logic e_pwm[2] = '{1'b0, 1'b0};
    logic e_ip = 1'b0;
    bit   m_bnd;
    bit   model_on = 1'b0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void decide(input int ch);
        int cmd;
        int tgt;
        cmd = m_cmd_dir[ch];
        tgt = imin(m_cmd_dc[ch], PER);
        if (m_mode[ch] == M_GAP) begin
            m_gap[ch] = m_gap[ch] - 1;
            if (m_gap[ch] > 0) return;
            m_mode[ch] = M_OFF;
        end
        if (cmd == 0) begin
            m_mode[ch] = M_OFF;
            m_duty[ch] = 0;
        end else if (cmd == 3) begin
            m_mode[ch] = M_HOLD;
            m_duty[ch] = 0;
        end else if (m_mode[ch] == M_DRIVE && cmd != m_sense[ch]) begin
            m_mode[ch] = M_GAP;
            m_gap[ch]  = DEADP;
            m_duty[ch] = 0;
        end else begin
            if (m_mode[ch] != M_DRIVE) begin
                m_mode[ch]  = M_DRIVE;
                m_sense[ch] = cmd;
                m_duty[ch]  = 0;
            end
            m_duty[ch] = imin(tgt, m_duty[ch] + RAMP);
        end
    endfunction

    function automatic void set_out(input int ch, input int cnt);
        bit drive, hold;
        drive = (m_mode[ch] == M_DRIVE);
        hold  = (m_mode[ch] == M_HOLD);
        e_in1[ch] = (drive && m_sense[ch] == 1) || hold;
        e_in2[ch] = (drive && m_sense[ch] == 2) || hold;
        e_pwm[ch] = (drive && cnt < m_duty[ch]) || hold;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_n = 0;
                e_ip = 1'b0;
                for (int ch = 0; ch < 2; ch++) begin
                    m_mode[ch] = M_OFF;
                    m_sense[ch] = 0;
                    m_duty[ch] = 0;
                    m_gap[ch] = 0;
                    m_cmd_dir[ch] = 0;
                    m_cmd_dc[ch] = 0;
                    set_out(ch, 0);
                end
            end else begin
                m_bnd = ((m_n % PS) == PS - 1) && (((m_n / PS) % PER) == PER - 1);
                if (m_bnd) begin
                    decide(0);
                    decide(1);
                end
                m_cmd_dir[0] = int'(dir_a);
                m_cmd_dc[0]  = int'(dc_a);
                m_cmd_dir[1] = int'(dir_b);
                m_cmd_dc[1]  = int'(dc_b);
                m_n = m_n + 1;
                e_ip = m_bnd;
                set_out(0, (m_n / PS) % PER);
                set_out(1, (m_n / PS) % PER);
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check_int(input string name, input int k, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s [%0d] t=%0t got=%0d want=%0d", name, k, $time, got, want);
        end
    endtask

    task automatic check_bits(input string name, input int k, input logic [6:0] got,
                              input logic [6:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s [%0d] t=%0t got=%b want=%b", name, k, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (model_on && !rst) begin
            check_bits("cycle_model", m_n,
                       {in1_a, in2_a, pwm_a, in1_b, in2_b, pwm_b, ip},
                       {e_in1[0], e_in2[0], e_pwm[0], e_in1[1], e_in2[1], e_pwm[1], e_ip});
        end
    end

    task automatic wait_ip(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ip !== 1'b1 && n < 200);
    endtask

    // ---------------- directed per-period table ----------------
    typedef struct {
        logic [1:0]  da;
        logic [11:0] ca;
        logic [1:0]  db;
        logic [11:0] cb;
        int          ha;
        logic        i1a;
        logic        i2a;
        int          hb;
        logic        i1b;
        logic        i2b;
    } vec_t;

    vec_t vecs[NV];
    vec_t zero_v;
    vec_t exp_v;

    task automatic apply(input vec_t v);
        dir_a = v.da;
        dc_a  = v.ca;
        dir_b = v.db;
        dc_b  = v.cb;
    endtask

    // Called on the first clk of a period; returns on its last clk.
    task automatic check_period(input vec_t e, input int k);
        int ha, hb;
        bit ia_ok, ib_ok, aligned;
        ha = 0;
        hb = 0;
        ia_ok = 1'b1;
        ib_ok = 1'b1;
        aligned = (ip === 1'b1);
        for (int i = 0; i < CLKS_PER; i++) begin
            if (i > 0) @(negedge clk);
            ha += int'(pwm_a);
            hb += int'(pwm_b);
            if ({in1_a, in2_a} !== {e.i1a, e.i2a}) ia_ok = 1'b0;
            if ({in1_b, in2_b} !== {e.i1b, e.i2b}) ib_ok = 1'b0;
        end
        check_int("period_align", k, int'(aligned), 1);
        check_int("pwm_a_high_clks", k, ha, e.ha * PS);
        check_int("pwm_b_high_clks", k, hb, e.hb * PS);
        check_int("in_a_steady", k, int'(ia_ok), 1);
        check_int("in_b_steady", k, int'(ib_ok), 1);
    endtask

    function automatic logic [11:0] pick_dc();
        case ($urandom_range(0, 5))
            0:       return 12'd0;
            1:       return 12'd4095;
            default: return 12'($urandom_range(0, 12));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1);
    end

    initial begin
        int n;
        zero_v = '{2'b00, 12'd0, 2'b00, 12'd0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        // {dirA, dcA, dirB, dcB | expected next period: hiA, in1A, in2A, hiB, in1B, in2B}
        vecs[0]  = '{2'b01, 12'd10,   2'b00, 12'd0, 3,  1'b1, 1'b0, 0,  1'b0, 1'b0};
        vecs[1]  = '{2'b01, 12'd10,   2'b00, 12'd0, 6,  1'b1, 1'b0, 0,  1'b0, 1'b0};
        vecs[2]  = '{2'b01, 12'd10,   2'b00, 12'd0, 9,  1'b1, 1'b0, 0,  1'b0, 1'b0};
        vecs[3]  = '{2'b01, 12'd4,    2'b00, 12'd0, 4,  1'b1, 1'b0, 0,  1'b0, 1'b0};
        vecs[4]  = '{2'b01, 12'd6,    2'b00, 12'd0, 6,  1'b1, 1'b0, 0,  1'b0, 1'b0};
        vecs[5]  = '{2'b10, 12'd6,    2'b11, 12'd0, 0,  1'b0, 1'b0, 10, 1'b1, 1'b1};
        vecs[6]  = '{2'b01, 12'd6,    2'b00, 12'd0, 0,  1'b0, 1'b0, 0,  1'b0, 1'b0};
        vecs[7]  = '{2'b10, 12'd6,    2'b00, 12'd0, 3,  1'b0, 1'b1, 0,  1'b0, 1'b0};
        vecs[8]  = '{2'b10, 12'd4095, 2'b00, 12'd0, 6,  1'b0, 1'b1, 0,  1'b0, 1'b0};
        vecs[9]  = '{2'b10, 12'd4095, 2'b00, 12'd0, 9,  1'b0, 1'b1, 0,  1'b0, 1'b0};
        vecs[10] = '{2'b10, 12'd4095, 2'b00, 12'd0, 10, 1'b0, 1'b1, 0,  1'b0, 1'b0};
        vecs[11] = '{2'b10, 12'd0,    2'b00, 12'd0, 0,  1'b0, 1'b1, 0,  1'b0, 1'b0};
        vecs[12] = '{2'b11, 12'd0,    2'b01, 12'd2, 10, 1'b1, 1'b1, 2,  1'b1, 1'b0};
        vecs[13] = '{2'b01, 12'd5,    2'b10, 12'd2, 3,  1'b1, 1'b0, 0,  1'b0, 1'b0};
        vecs[14] = '{2'b00, 12'd5,    2'b10, 12'd2, 0,  1'b0, 1'b0, 0,  1'b0, 1'b0};
        vecs[15] = '{2'b00, 12'd0,    2'b10, 12'd2, 0,  1'b0, 1'b0, 2,  1'b0, 1'b1};
        vecs[16] = '{2'b00, 12'd0,    2'b11, 12'd2, 0,  1'b0, 1'b0, 10, 1'b1, 1'b1};
        vecs[17] = '{2'b01, 12'd10,   2'b11, 12'd2, 3,  1'b1, 1'b0, 10, 1'b1, 1'b1};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_on = 1'b1;
        check_bits("reset_outputs", 0, {in1_a, in2_a, pwm_a, in1_b, in2_b, pwm_b, ip}, 7'b0);
        rst = 1'b0;
        wait_ip(n);
        check_int("first_pulse_clks", 0, n, CLKS_PER);

        for (int k = 0; k <= NV; k++) begin
            if (k < NV) apply(vecs[k]);
            if (k == 0) exp_v = zero_v;
            else exp_v = vecs[k - 1];
            check_period(exp_v, k);
            @(negedge clk);
        end

        // Mid-period reset while A is driving forward and B is braking.
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_bits("reset_async", 1, {in1_a, in2_a, pwm_a, in1_b, in2_b, pwm_b, ip}, 7'b0);
        repeat (2) @(negedge clk);
        check_bits("reset_hold", 1, {in1_a, in2_a, pwm_a, in1_b, in2_b, pwm_b, ip}, 7'b0);
        rst = 1'b0;
        wait_ip(n);
        check_int("first_pulse_after_rst", 1, n, CLKS_PER);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                dir_a = 2'($urandom_range(0, 3));
                dc_a  = pick_dc();
            end
            if ($urandom_range(0, 39) == 0) begin
                dir_b = 2'($urandom_range(0, 3));
                dc_b  = pick_dc();
            end
            if ($urandom_range(0, 999) == 0) begin
                #3;
                rst = 1'b1;
                #1;
                check_bits("rand_reset_async", i,
                           {in1_a, in2_a, pwm_a, in1_b, in2_b, pwm_b, ip}, 7'b0);
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
